move_dispatcher: RTL and testbench
==================================

MOVE_DISPATCHER -- requirements
Module: move_dispatcher

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 16, max checker wait cycles after dispatch (range 2..255).
REQ-002 clk  input  1  system clock; all logic on posedge.
REQ-003 reset_n  input  1  synchronous, active-low reset.
REQ-004 req_valid / req_ready  input / output  1 / 1  move request handshake; transfer when both high.
REQ-005 old_x, old_y, new_x, new_y  input  3 each  source/destination square; board indexed board_in[y][x].
REQ-006 board_in  input  4 x [8][8]  piece codes; 0-5 own P,N,B,R,Q,K; 6-11 opponent; 15 empty; 12-14 invalid.
REQ-007 chk_old_x, chk_old_y, chk_new_x, chk_new_y  output  3 each  latched coordinates to checkers.
REQ-008 chk_h_delta, chk_v_delta  output  3 each  absolute |new_x-old_x|, |new_y-old_y|.
REQ-009 chk_piece_type  output  4  latched source piece code.
REQ-010 chk_valid_input  output  6  one-hot start pulse, bit i = checker for own piece code i.
REQ-011 chk_valid_move, chk_valid_output  input  6 each  per-checker verdict and done.
REQ-012 res_valid / res_ready  output / input  1 / 1  result handshake.
REQ-013 res_legal  output  1  move legal; res_code  output  3  result code.

Function
REQ-014 FSM states IDLE, PRECHECK, DISPATCH, WAIT, RESPOND; any other encoding returns to IDLE next cycle.
REQ-015 IDLE: req_ready=1; on req_valid latch coordinates, compute deltas, sample board_in[old_y][old_x] and board_in[new_y][new_x] -> PRECHECK.
REQ-016 req_ready SHALL be 0 in every state except IDLE.
REQ-017 PRECHECK, priority order: src==dst -> code 4 NULL; src==15 -> code 1 SRC_EMPTY; src 6-14 -> code 2 SRC_NOT_OWN; dst 0-5 -> code 3 DST_OWN; any reject -> RESPOND with res_legal=0; else -> DISPATCH.
REQ-018 DISPATCH: chk_valid_input[piece] high exactly one cycle, then -> WAIT; chk_* coordinate/delta/type outputs stable from PRECHECK until leaving WAIT.
REQ-019 WAIT: only selected checker's chk_valid_output observed, first sampled the cycle after the start pulse; when high, res_legal=chk_valid_move[piece], code 0 OK or 5 ILLEGAL -> RESPOND.
REQ-020 Unselected checkers' outputs SHALL never affect state or result.
REQ-021 RESPOND: res_valid=1, res_legal/res_code held stable until res_ready sampled high; then -> IDLE, res_valid=0 next cycle.
REQ-022 Latency: reject = req accept +2 cycles to res_valid; dispatched = checker done +1 cycle to res_valid.
REQ-023 req_valid during non-IDLE ignored (no queuing); back-to-back requests need one IDLE cycle.
REQ-024 Deltas computed unsigned with 3-bit absolute difference; no wrap (0..7 only).

Reset
REQ-025 reset_n low at posedge: state=IDLE, req_ready=1, res_valid=0, res_legal=0, res_code=0, chk_valid_input=0, chk_* data=0, timeout counter=0.
REQ-026 Reset mid-WAIT/RESPOND aborts transaction; no result emitted; late checker done after reset ignored.

Configuration
REQ-027 Macro DISPATCH_TIMEOUT_EN defined: 8-bit counter cleared at DISPATCH, increments in WAIT; reaching TIMEOUT_CYCLES without done -> RESPOND, res_legal=0, code 6 TIMEOUT; done and timeout same cycle -> done wins.
REQ-028 Macro undefined: no counter; WAIT persists until selected checker done; code 6 never produced.

Structure
REQ-029 Shared package chess_pkg: piece-code constants (incl. EMPTY=15), result-code enum (OK, SRC_EMPTY, SRC_NOT_OWN, DST_OWN, NULL, ILLEGAL, TIMEOUT), FSM state typedef.
REQ-030 One sub-module move_precheck: combinational src/dst classification and reject-code priority of REQ-017; FSM/handshakes in move_dispatcher.

Verification
REQ-031 Own pawn (0) at (4,6), empty (4,4)/(4,5), req (4,6)->(4,4): chk_valid_input=6'b000001 one cycle, h=0, v=2; checker done+move=1 -> res_legal=1, code 0.
REQ-032 Source (2,2)=15 -> no start pulse, res_valid 2 cycles after accept, res_legal=0, code 1.
REQ-033 Own rook (3) src, own knight (1) dst -> code 3; src==dst (5,5)->(5,5) with own piece -> code 4.
REQ-034 Knight dispatched, checker returns done+move=0 while pawn checker holds done=1 -> res_legal=0, code 5; res_ready low 10 cycles -> outputs stable.
REQ-035 DISPATCH_TIMEOUT_EN, TIMEOUT_CYCLES=4, checker silent -> res_legal=0, code 6 after 4 WAIT cycles; undefined build -> still WAIT at 100 cycles.
REQ-036 reset_n low in WAIT, then checker done -> no res_valid, req_ready=1.

Source files
------------

// File: rtl/chess_pkg.sv
// Shared piece codes, result codes and dispatcher state encoding for the move
// dispatcher and its precheck helper.
package chess_pkg;

  localparam logic [3:0] PC_PAWN      = 4'd0;
  localparam logic [3:0] PC_KNIGHT    = 4'd1;
  localparam logic [3:0] PC_BISHOP    = 4'd2;
  localparam logic [3:0] PC_ROOK      = 4'd3;
  localparam logic [3:0] PC_QUEEN     = 4'd4;
  localparam logic [3:0] PC_KING      = 4'd5;
  localparam logic [3:0] PC_OPP_FIRST = 4'd6;
  localparam logic [3:0] PC_EMPTY     = 4'd15;

  typedef enum logic [2:0] {
    RES_OK          = 3'd0,
    RES_SRC_EMPTY   = 3'd1,
    RES_SRC_NOT_OWN = 3'd2,
    RES_DST_OWN     = 3'd3,
    RES_NULL        = 3'd4,
    RES_ILLEGAL     = 3'd5,
    RES_TIMEOUT     = 3'd6
  } res_code_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PRECHECK = 3'd1,
    ST_DISPATCH = 3'd2,
    ST_WAIT     = 3'd3,
    ST_RESPOND  = 3'd4
  } state_t;

  function automatic logic is_own(input logic [3:0] pc);
    return pc < PC_OPP_FIRST;
  endfunction

  function automatic logic [5:0] piece_onehot(input logic [2:0] pc);
    return 6'(6'b000001 << pc);
  endfunction

  function automatic logic [2:0] abs_diff3(input logic [2:0] a, input logic [2:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/move_dispatcher_if.sv
// Request, board, checker and result signals of the move dispatcher.
// slave = dispatcher side, master = requester/checker side.
interface move_dispatcher_if;
  logic                 req_valid;
  logic                 req_ready;
  logic [2:0]           old_x, old_y, new_x, new_y;
  logic [7:0][7:0][3:0] board_in;
  logic [2:0]           chk_old_x, chk_old_y, chk_new_x, chk_new_y;
  logic [2:0]           chk_h_delta, chk_v_delta;
  logic [3:0]           chk_piece_type;
  logic [5:0]           chk_valid_input;
  logic [5:0]           chk_valid_move;
  logic [5:0]           chk_valid_output;
  logic                 res_valid;
  logic                 res_ready;
  logic                 res_legal;
  logic [2:0]           res_code;

  modport slave (
    input  req_valid, old_x, old_y, new_x, new_y, board_in,
           chk_valid_move, chk_valid_output, res_ready,
    output req_ready, chk_old_x, chk_old_y, chk_new_x, chk_new_y,
           chk_h_delta, chk_v_delta, chk_piece_type, chk_valid_input,
           res_valid, res_legal, res_code
  );

  modport master (
    output req_valid, old_x, old_y, new_x, new_y, board_in,
           chk_valid_move, chk_valid_output, res_ready,
    input  req_ready, chk_old_x, chk_old_y, chk_new_x, chk_new_y,
           chk_h_delta, chk_v_delta, chk_piece_type, chk_valid_input,
           res_valid, res_legal, res_code
  );
endinterface

// File: rtl/move_precheck.sv
// Combinational source/destination screening; reports the highest-priority
// reject reason, or no reject when the move can go to a checker.
module move_precheck
  import chess_pkg::*;
(
  input  logic [3:0] src_piece,
  input  logic [3:0] dst_piece,
  input  logic       same_sq,
  output logic       reject,
  output res_code_t  code
);

  always_comb begin
    reject = 1'b1;
    code   = RES_OK;
    if (same_sq)                   code = RES_NULL;
    else if (src_piece == PC_EMPTY) code = RES_SRC_EMPTY;
    else if (!is_own(src_piece))    code = RES_SRC_NOT_OWN;
    else if (is_own(dst_piece))     code = RES_DST_OWN;
    else                            reject = 1'b0;
  end

endmodule

// File: rtl/move_dispatcher.sv
// Move dispatcher: accepts a move, screens it, starts the matching piece
// checker and returns its verdict. DISPATCH_TIMEOUT_EN adds a WAIT timeout.
//
// state       | meaning
// ST_IDLE     | ready for a request, latch coordinates and board squares
// ST_PRECHECK | screen src/dst, reject straight to RESPOND
// ST_DISPATCH | one-cycle start pulse to the selected checker
// ST_WAIT     | wait for the selected checker's done (or timeout)
// ST_RESPOND  | hold result until res_ready
module move_dispatcher
  import chess_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic             clk,
  input logic             reset_n,
  move_dispatcher_if.slave bus
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("move_dispatcher: TIMEOUT_CYCLES must be 2..255");
  end

  state_t     state;
  logic [3:0] dst_piece;
  logic [5:0] sel_mask;
  logic       same_sq;
  logic       pre_reject;
  res_code_t  pre_code;
  logic       sel_done;
  logic       sel_move;

  assign same_sq  = (bus.chk_old_x == bus.chk_new_x) && (bus.chk_old_y == bus.chk_new_y);
  // Only the dispatched checker is looked at; the others are masked off.
  assign sel_done = |(bus.chk_valid_output & sel_mask);
  assign sel_move = |(bus.chk_valid_move & sel_mask);

`ifdef DISPATCH_TIMEOUT_EN
  logic [7:0] tmo_cnt;
  logic       tmo_hit;
  assign tmo_hit = (tmo_cnt == 8'(TIMEOUT_CYCLES - 1));
`endif

  move_precheck u_precheck (
    .src_piece (bus.chk_piece_type),
    .dst_piece (dst_piece),
    .same_sq   (same_sq),
    .reject    (pre_reject),
    .code      (pre_code)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state               <= ST_IDLE;
      bus.req_ready       <= 1'b1;
      bus.res_valid       <= 1'b0;
      bus.res_legal       <= 1'b0;
      bus.res_code        <= RES_OK;
      bus.chk_valid_input <= '0;
      bus.chk_old_x       <= '0;
      bus.chk_old_y       <= '0;
      bus.chk_new_x       <= '0;
      bus.chk_new_y       <= '0;
      bus.chk_h_delta     <= '0;
      bus.chk_v_delta     <= '0;
      bus.chk_piece_type  <= '0;
      dst_piece           <= '0;
      sel_mask            <= '0;
`ifdef DISPATCH_TIMEOUT_EN
      tmo_cnt             <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            bus.chk_old_x      <= bus.old_x;
            bus.chk_old_y      <= bus.old_y;
            bus.chk_new_x      <= bus.new_x;
            bus.chk_new_y      <= bus.new_y;
            bus.chk_h_delta    <= abs_diff3(bus.new_x, bus.old_x);
            bus.chk_v_delta    <= abs_diff3(bus.new_y, bus.old_y);
            bus.chk_piece_type <= bus.board_in[bus.old_y][bus.old_x];
            dst_piece          <= bus.board_in[bus.new_y][bus.new_x];
            bus.req_ready      <= 1'b0;
            state              <= ST_PRECHECK;
          end
        end
        ST_PRECHECK: begin
          if (pre_reject) begin
            bus.res_valid <= 1'b1;
            bus.res_legal <= 1'b0;
            bus.res_code  <= pre_code;
            state         <= ST_RESPOND;
          end else begin
            bus.chk_valid_input <= piece_onehot(bus.chk_piece_type[2:0]);
            sel_mask            <= piece_onehot(bus.chk_piece_type[2:0]);
            state               <= ST_DISPATCH;
          end
        end
        ST_DISPATCH: begin
          bus.chk_valid_input <= '0;
`ifdef DISPATCH_TIMEOUT_EN
          tmo_cnt             <= '0;
`endif
          state               <= ST_WAIT;
        end
        ST_WAIT: begin
          if (sel_done) begin
            bus.res_valid <= 1'b1;
            bus.res_legal <= sel_move;
            bus.res_code  <= sel_move ? RES_OK : RES_ILLEGAL;
            state         <= ST_RESPOND;
          end
`ifdef DISPATCH_TIMEOUT_EN
          else if (tmo_hit) begin
            bus.res_valid <= 1'b1;
            bus.res_legal <= 1'b0;
            bus.res_code  <= RES_TIMEOUT;
            state         <= ST_RESPOND;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
`endif
        end
        ST_RESPOND: begin
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            bus.req_ready <= 1'b1;
            state         <= ST_IDLE;
          end
        end
        default: begin
          bus.res_valid       <= 1'b0;
          bus.chk_valid_input <= '0;
          bus.req_ready       <= 1'b1;
          state               <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_move_dispatcher.sv
// Directed bench for move_dispatcher: a transaction-level expectation model
// checked against the DUT every cycle, plus literal per-vector results.
module tb_move_dispatcher;

`ifdef DISPATCH_TIMEOUT_EN
  localparam int TB_TMO = 4;
`else
  localparam int TB_TMO = 16;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  move_dispatcher_if dif ();

  move_dispatcher #(.TIMEOUT_CYCLES(TB_TMO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (dif.slave)
  );

  int vectors = 0;
  int misses  = 0;

  logic                 chk_on = 1'b0;
  logic                 exp_req_ready, exp_res_valid, exp_legal, exp_data_on;
  logic [2:0]           exp_code;
  logic [5:0]           exp_start;
  logic [2:0]           exp_ox, exp_oy, exp_nx, exp_ny, exp_h, exp_v;
  logic [3:0]           exp_type;
  logic [7:0][7:0][3:0] brd;

  assign dif.board_in = brd;

  typedef struct {
    int         ox, oy, nx, ny;
    int         done_at;   // WAIT cycle the selected checker finishes, -1 = never
    logic       move;
    logic [5:0] noise;     // unselected checkers reporting done+legal
    int         rdly;      // cycles res_ready stays low in RESPOND
    int         lit_code, lit_h, lit_v;
    logic       busy;      // keep requesting while the dispatcher is busy
  } vec_t;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      misses++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] model_abs(input int a, input int b);
    int d;
    d = a - b;
    return 3'(d < 0 ? -d : d);
  endfunction

  // Result code for a rejected move, or -1 when the move goes to a checker.
  function automatic int model_precheck(input int ox, input int oy, input int nx, input int ny);
    int s, d;
    s = int'(brd[oy][ox]);
    d = int'(brd[ny][nx]);
    if (ox == nx && oy == ny) return 4;
    if (s == 15)              return 1;
    if (s >= 6)               return 2;
    if (d <= 5)               return 3;
    return -1;
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      cmp("req_ready", dif.req_ready, exp_req_ready);
      cmp("res_valid", dif.res_valid, exp_res_valid);
      cmp("chk_valid_input", dif.chk_valid_input, exp_start);
      if (exp_res_valid) begin
        cmp("res_legal", dif.res_legal, exp_legal);
        cmp("res_code", dif.res_code, exp_code);
      end
      if (exp_data_on) begin
        cmp("chk_old_x", dif.chk_old_x, exp_ox);
        cmp("chk_old_y", dif.chk_old_y, exp_oy);
        cmp("chk_new_x", dif.chk_new_x, exp_nx);
        cmp("chk_new_y", dif.chk_new_y, exp_ny);
        cmp("chk_h_delta", dif.chk_h_delta, exp_h);
        cmp("chk_v_delta", dif.chk_v_delta, exp_v);
        cmp("chk_piece_type", dif.chk_piece_type, exp_type);
      end
    end
  end

  task automatic do_move(input vec_t v, input int limit, output logic stuck);
    int         code, src;
    logic       resp;
    logic [5:0] sel;
    code  = model_precheck(v.ox, v.oy, v.nx, v.ny);
    src   = int'(brd[v.oy][v.ox]);
    sel   = 6'(1 << (src % 8));
    resp  = 1'b0;
    stuck = 1'b0;
    dif.old_x = 3'(v.ox); dif.old_y = 3'(v.oy);
    dif.new_x = 3'(v.nx); dif.new_y = 3'(v.ny);
    dif.req_valid = 1'b1;
    tick();
    dif.req_valid = v.busy;
    if (v.busy) begin
      dif.old_x = 3'(v.nx); dif.old_y = 3'(v.ny);
      dif.new_x = 3'(v.ox); dif.new_y = 3'(v.oy);
    end
    exp_req_ready = 1'b0;
    exp_ox = 3'(v.ox); exp_oy = 3'(v.oy); exp_nx = 3'(v.nx); exp_ny = 3'(v.ny);
    exp_h  = model_abs(v.nx, v.ox);
    exp_v  = model_abs(v.ny, v.oy);
    exp_type    = 4'(src);
    exp_data_on = 1'b1;
    cmp("lit_h_delta", dif.chk_h_delta, v.lit_h);
    cmp("lit_v_delta", dif.chk_v_delta, v.lit_v);
    if (code >= 0) begin
      tick();
      exp_res_valid = 1'b1; exp_legal = 1'b0; exp_code = 3'(code);
      resp = 1'b1;
    end else begin
      tick();
      exp_start = sel;
      dif.chk_valid_output = v.noise;
      dif.chk_valid_move   = v.noise;
      tick();
      exp_start = '0;
      for (int w = 1; w <= limit; w++) begin
        if (w == v.done_at) begin
          dif.chk_valid_output = v.noise | sel;
          dif.chk_valid_move   = v.move ? (v.noise | sel) : v.noise;
        end
        tick();
        if (w == v.done_at) begin
          exp_res_valid = 1'b1; exp_legal = v.move; exp_code = v.move ? 3'd0 : 3'd5;
          resp = 1'b1;
          break;
        end
`ifdef DISPATCH_TIMEOUT_EN
        if (w == TB_TMO) begin
          exp_res_valid = 1'b1; exp_legal = 1'b0; exp_code = 3'd6;
          resp = 1'b1;
          break;
        end
`endif
      end
      dif.chk_valid_output = v.noise;
    end
    if (!resp) begin
      stuck = 1'b1;
      return;
    end
    cmp("lit_res_code", dif.res_code, v.lit_code);
    for (int r = 0; r < v.rdly; r++) tick();
    dif.res_ready = 1'b1;
    tick();
    dif.res_ready = 1'b0;
    dif.req_valid = 1'b0;
    dif.chk_valid_output = '0;
    dif.chk_valid_move   = '0;
    exp_res_valid = 1'b0;
    exp_req_ready = 1'b1;
    exp_data_on   = 1'b0;
  endtask

  // Reset taken while a transaction is pending; a late checker done must not revive it.
  task automatic reset_abort(input string tag);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    exp_req_ready = 1'b1; exp_res_valid = 1'b0; exp_start = '0;
    exp_ox = '0; exp_oy = '0; exp_nx = '0; exp_ny = '0;
    exp_h = '0; exp_v = '0; exp_type = '0; exp_data_on = 1'b1;
    cmp({tag, "_res_legal"}, dif.res_legal, 1'b0);
    cmp({tag, "_res_code"}, dif.res_code, 3'd0);
    dif.chk_valid_output = 6'h3f;
    dif.chk_valid_move   = 6'h3f;
    repeat (3) tick();
    cmp({tag, "_req_ready"}, dif.req_ready, 1'b1);
    dif.chk_valid_output = '0;
    dif.chk_valid_move   = '0;
    exp_data_on = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
    $fatal(1);
  end

  initial begin
    vec_t vecs [10];
    logic stuck;
    dif.req_valid = 1'b0; dif.res_ready = 1'b0;
    dif.old_x = '0; dif.old_y = '0; dif.new_x = '0; dif.new_y = '0;
    dif.chk_valid_output = '0; dif.chk_valid_move = '0;
    brd = {64{4'hF}};
    brd[6][4] = 4'd0;   // own pawn
    brd[0][0] = 4'd3;   // own rook
    brd[3][0] = 4'd1;   // own knight as destination
    brd[5][5] = 4'd4;   // own queen
    brd[7][7] = 4'd8;   // opponent bishop
    brd[7][1] = 4'd13;  // invalid code
    brd[0][6] = 4'd1;   // own knight
    brd[0][4] = 4'd5;   // own king
    brd[1][4] = 4'd6;   // opponent pawn
    brd[0][7] = 4'd2;   // own bishop

    vecs[0] = '{4, 6, 4, 4,  2, 1'b1, 6'b000000,  0, 0, 0, 2, 1'b0};
    vecs[1] = '{2, 2, 2, 3, -1, 1'b0, 6'b000000,  0, 1, 0, 1, 1'b0};
    vecs[2] = '{0, 0, 0, 3, -1, 1'b0, 6'b000000,  0, 3, 0, 3, 1'b0};
    vecs[3] = '{5, 5, 5, 5, -1, 1'b0, 6'b000000,  0, 4, 0, 0, 1'b0};
    vecs[4] = '{7, 7, 6, 6, -1, 1'b0, 6'b000000,  1, 2, 1, 1, 1'b0};
    vecs[5] = '{1, 7, 1, 6, -1, 1'b0, 6'b000000,  2, 2, 0, 1, 1'b1};
    vecs[6] = '{6, 0, 5, 2,  3, 1'b0, 6'b000001, 10, 5, 1, 2, 1'b0};
    vecs[7] = '{4, 0, 4, 1,  1, 1'b1, 6'b011111,  2, 0, 0, 1, 1'b1};
    vecs[8] = '{7, 0, 0, 7,  1, 1'b1, 6'b000000,  0, 0, 7, 7, 1'b0};
    vecs[9] = '{3, 3, 3, 3, -1, 1'b0, 6'b000000,  0, 4, 0, 0, 1'b0};

    repeat (2) tick();
    reset_n = 1'b1;
    exp_req_ready = 1'b1; exp_res_valid = 1'b0; exp_legal = 1'b0; exp_code = '0;
    exp_start = '0;
    exp_ox = '0; exp_oy = '0; exp_nx = '0; exp_ny = '0;
    exp_h = '0; exp_v = '0; exp_type = '0; exp_data_on = 1'b1;
    chk_on = 1'b1;
    cmp("reset_res_legal", dif.res_legal, 1'b0);
    cmp("reset_res_code", dif.res_code, 3'd0);
    tick();

    foreach (vecs[i]) begin
      do_move(vecs[i], 100, stuck);
      cmp("vector_completed", stuck, 1'b0);
    end

    // Queen dispatched, reset arrives while waiting for its checker.
    do_move('{5, 5, 5, 1, -1, 1'b0, 6'b000000, 0, 0, 0, 4, 1'b0}, 2, stuck);
    cmp("abort_reached_wait", stuck, 1'b1);
    reset_abort("wait_abort");

`ifdef DISPATCH_TIMEOUT_EN
    do_move('{6, 0, 7, 2, -1, 1'b0, 6'b000000, 0, 6, 1, 2, 1'b0}, 100, stuck);
    cmp("timeout_completed", stuck, 1'b0);
    do_move('{6, 0, 7, 2, TB_TMO, 1'b1, 6'b000000, 0, 0, 1, 2, 1'b0}, 100, stuck);
    cmp("done_beats_timeout", stuck, 1'b0);
`else
    do_move('{6, 0, 7, 2, -1, 1'b0, 6'b000000, 0, 0, 1, 2, 1'b0}, 100, stuck);
    cmp("silent_still_waiting", stuck, 1'b1);
    cmp("silent_res_valid", dif.res_valid, 1'b0);
    reset_abort("silent_abort");
`endif

    tick();
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
